uart_rom_loader: RTL
====================

# uart_rom_loader

Boot-time program loader for the tinyrisc_v SoC. It receives a framed binary image on a UART RX pin and writes it word by word into the instruction ROM through the ROM's write port. This is the in-hardware counterpart of loading the ROM from a file in simulation. The core is held in reset until a complete, checksum-verified image has been written. After that, the core is released and the loader goes inert.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD, 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division)
- ADDR_W, 12, ROM word-address width; capacity = 2^ADDR_W words

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rxd  in  1  UART receive line, idle high, 8N1, LSB first
- rom_we  out  1  ROM write strobe, one-cycle pulse per word
- rom_addr  out  ADDR_W  ROM word address for the current write
- rom_wdata  out  32  ROM write data
- core_rst_n  out  1  reset to tinyrisc_v core, low = held in reset
- load_done  out  1  image loaded and verified (sticky)
- load_err  out  1  frame/length/checksum error (sticky until next sync byte)

## Operation
- Frame format: 0xA5 sync, LEN_L, LEN_H (word count N, little-endian), N×4 data bytes (each word little-endian, byte0 = bits 7:0), CHK.
- CHK = XOR of all 4N data bytes. When N = 0, CHK must be 0x00.
- FSM states:
  - IDLE: wait for a received byte of 0xA5; all other bytes are ignored. Go to LEN_L.
  - LEN_L: latch the low byte of N. Go to LEN_H.
  - LEN_H: latch the high byte of N. If N > 2^ADDR_W, go to ERR. If N = 0, go to CHK. Otherwise go to DATA with word_cnt = 0 and byte_idx = 0.
  - DATA: shift each byte into the word assembler and fold it into the running XOR.
    - On byte_idx = 3: issue the write at rom_addr = word_cnt, then increment word_cnt.
    - After word N-1, go to CHK.
  - CHK: compare the received byte with the running XOR. Match → DONE; mismatch → ERR.
  - DONE: core_rst_n = 1, load_done = 1. All further rxd activity is ignored until rst.
  - ERR: load_err = 1, core_rst_n = 0. A received 0xA5 clears load_err, resets the XOR and counters, and goes to LEN_L.
- A stop bit sampled low (framing error) in any state except IDLE, DONE or ERR sends the FSM to ERR. Framing errors in IDLE are ignored.
- Data is written before the checksum is verified. Correctness relies on the core staying in reset until DONE.
- uart_rx behaviour:
  - Two-flop synchronizer on rxd.
  - A start bit is accepted on a falling edge and confirmed low at CLKS_PER_BIT/2.
  - Data bits are sampled at bit centres.
  - Output is a one-cycle rx_valid with rx_data[7:0] and rx_ferr.
  - A false start (line high at the half-bit point) returns it to idle with no output.

## Timing
- Reset values: rom_we = 0, rom_addr = 0, rom_wdata = 0, core_rst_n = 0, load_done = 0, load_err = 0, FSM = IDLE.
- rom_we is asserted exactly 1 cycle after the rx_valid of each word's 4th byte. rom_addr and rom_wdata are stable during that cycle.
- core_rst_n and load_done rise together, 1 cycle after the rx_valid of a correct CHK byte.
- load_err rises 1 cycle after the offending rx_valid.
- Byte latency: rx_valid arrives roughly 9.5 bit times after the start-bit falling edge, plus 2 synchronizer cycles.
- Reset mid-frame: all state clears immediately and asynchronously. Partially written ROM content is not cleared. Reception restarts at IDLE, and a byte in flight is discarded.
- N = 2^ADDR_W is legal; the last write goes to address 2^ADDR_W-1. word_cnt must be ADDR_W+1 bits wide so it does not wrap.

## Structure
- A shared package holds: SYNC_BYTE = 8'hA5, the FSM state encoding, and the 8N1 bit-count constants.
- One sub-module, uart_rx, contains the synchronizer, bit timer and shift register, and produces rx_valid, rx_data and rx_ferr.
- The top level contains the FSM, word assembler, XOR accumulator, counters, and output registers.

## Test plan
All scenarios use CLK_FREQ = 1_000_000, BAUD = 100_000 (10 clks/bit) and ADDR_W = 4.
- Image A5 02 00 | 13 00 00 00 | B7 10 00 00 | CHK 0xB4 → writes (0, 0x00000013) and (1, 0x000010B7), one rom_we pulse each; load_done = 1 and core_rst_n = 1 one cycle after CHK.
- Same frame with CHK 0x00 → both writes occur, then load_err = 1, core_rst_n stays 0, load_done stays 0.
  - Follow with the correct frame → load_err clears on 0xA5, ends in DONE.
- Garbage bytes 0x00, 0xFF, 0x13 before A5, then A5 00 00 00 → no writes, load_done = 1.
- A5 11 00 (N = 17 > 16) → load_err = 1 after LEN_H, no rom_we.
- Stop bit forced low on the 3rd data byte → load_err = 1, no rom_we for that word.
  - Also: a 3-clk low glitch on rxd in IDLE → no rx_valid.
- Assert rst low after 5 data bytes, then release and send a full valid frame → outputs return to reset values immediately; the new frame loads correctly and core_rst_n rises.

Source files
------------

// File: rtl/uart_rom_loader_pkg.sv
// Shared definitions for the UART boot loader.
//   SYNC_BYTE      : frame start marker
//   UART_DATA_BITS : data bits per 8N1 character
//   ldr_state_t    : loader FSM encoding
//   rx_state_t     : UART receiver FSM encoding
package uart_rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN_L = 3'd1,
    ST_LEN_H = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } ldr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rom_loader_rx.sv
// 8N1 UART receiver.
//   clk, rst (async, active-low)
//   rxd      : raw serial input, idle high
//   rx_valid : one-cycle strobe per received character
//   rx_data  : received byte, valid with rx_valid
//   rx_ferr  : stop bit was sampled low, valid with rx_valid
module uart_rx
  import uart_rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    ferr_d    = ferr_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q && prev_q) state_d = RX_START;
      end
      // Re-check the line mid start bit so short glitches are rejected.
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          ferr_d  = ~sync2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_valid = valid_q;
  assign rx_data  = data_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Boot-time image loader: receives a framed image over UART and writes it
// into the instruction ROM, holding the core in reset until the image
// checksum has been verified.
//   clk, rst (async, active-low), rxd : clock, reset, serial input
//   rom_we, rom_addr, rom_wdata       : ROM write port (one pulse per word)
//   core_rst_n                        : core reset, released on success
//   load_done, load_err               : sticky status flags
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [16:0] CAPACITY     = 17'd1 << ADDR_W;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  ldr_state_t        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        xor_q, xor_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic [15:0]     len_full;
  logic [ADDR_W:0] word_cnt_nxt;
  logic            sync_rx;

  assign len_full     = {rx_data, len_q[7:0]};
  assign word_cnt_nxt = word_cnt_q + 1'b1;
  assign sync_rx      = rx_valid && !rx_ferr && (rx_data == SYNC_BYTE);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    xor_d        = xor_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_wdata_d  = rom_wdata_q;
    core_rst_n_d = core_rst_n_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        // A sync byte (re)starts a frame; framing errors here are ignored.
        if (sync_rx) begin
          state_d    = ST_LEN_L;
          load_err_d = 1'b0;
          xor_d      = '0;
          word_cnt_d = '0;
          byte_idx_d = '0;
        end
      end
      ST_LEN_L, ST_LEN_H, ST_DATA, ST_CHK: begin
        if (rx_valid && rx_ferr) begin
          state_d    = ST_ERR;
          load_err_d = 1'b1;
        end else if (rx_valid) begin
          case (state_q)
            ST_LEN_L: begin
              len_d[7:0] = rx_data;
              state_d    = ST_LEN_H;
            end
            ST_LEN_H: begin
              len_d[15:8] = rx_data;
              if ({1'b0, len_full} > CAPACITY) begin
                state_d    = ST_ERR;
                load_err_d = 1'b1;
              end else if (len_full == 16'd0) begin
                state_d = ST_CHK;
              end else begin
                state_d    = ST_DATA;
                word_cnt_d = '0;
                byte_idx_d = '0;
              end
            end
            ST_DATA: begin
              xor_d      = xor_q ^ rx_data;
              byte_idx_d = byte_idx_q + 2'd1;
              case (byte_idx_q)
                2'd0: asm_d[7:0]   = rx_data;
                2'd1: asm_d[15:8]  = rx_data;
                2'd2: asm_d[23:16] = rx_data;
                default: begin
                  rom_we_d    = 1'b1;
                  rom_addr_d  = word_cnt_q[ADDR_W-1:0];
                  rom_wdata_d = {rx_data, asm_q};
                  word_cnt_d  = word_cnt_nxt;
                  if (17'(word_cnt_nxt) == {1'b0, len_q}) state_d = ST_CHK;
                end
              endcase
            end
            default: begin
              if (rx_data == xor_q) begin
                state_d      = ST_DONE;
                load_done_d  = 1'b1;
                core_rst_n_d = 1'b1;
              end else begin
                state_d    = ST_ERR;
                load_err_d = 1'b1;
              end
            end
          endcase
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      xor_q        <= '0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      xor_q        <= xor_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_wdata_q  <= rom_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
